kmeans_iter_ctrl: RTL and testbench
===================================

// Module: kmeans_iter_ctrl
// PURPOSE
//  Sequencer for the k-means engine. Owns the 4096x16 single-port data SRAM.
//  It streams the point set into the SRAM, then runs repeated read sweeps that feed the distance/accumulate datapath.
//  After each sweep it handshakes a centroid update, and stops on convergence or on an iteration limit.
//  It sits between the host load stream, the SRAM macro and the kMeans datapath.
// PARAMETERS
//  ADDR_W   12  SRAM address width (depth 2**ADDR_W)
//  DATA_W   16  point width, {x[15:8], y[7:0]}
//  MEM_LAT  2   cycles from mem_addr to valid mem_rdata at this block's input (1..4)
//  MAX_ITER 64  iteration limit (1..255)
// PORTS
//  clk        in  1       clock
//  rst_n      in  1       asynchronous active-low reset
//  start      in  1       job start pulse; honoured only in IDLE
//  n_points   in  13      point count, sampled on start
//  ld_valid   in  1       load stream valid
//  ld_data    in  DATA_W  load stream point
//  ld_ready   out 1       load stream ready
//  mem_addr   out ADDR_W  SRAM address
//  mem_din    out DATA_W  SRAM write data
//  mem_web    out 1       SRAM write enable, active low
//  mem_rdata  in  DATA_W  SRAM read data
//  pt_valid   out 1       point to datapath valid
//  pt_data    out DATA_W  point to datapath
//  pt_last    out 1       marks the final point of a sweep
//  upd_req    out 1       centroid update request; level signal, held until ack
//  upd_ack    in  1       update done
//  upd_conv   in  1       converged flag, sampled only with upd_ack
//  busy       out 1       high in every state except IDLE
//  done       out 1       one-cycle completion pulse
//  iter_count out 8       completed iterations; cleared on start, held after DONE
//  timeout    out 1       DONE reached through MAX_ITER; sticky until next start
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: mem_web=1; every other output 0; state=IDLE.
//  - Reset asserted mid-operation aborts immediately. No write is issued after rst_n falls.
//  - States: IDLE, LOAD, SWEEP, DRAIN, UPDATE, DONE.
//  - IDLE -> LOAD on start.
//      - n_points is latched as N. Values >4096 clamp to 4096.
//      - N==0: go IDLE->DONE instead, with iter_count=0 and no load.
//  - LOAD:
//      - ld_ready=1.
//      - Each ld_valid&ld_ready handshake drives mem_addr=cnt, mem_din=ld_data, mem_web=0 on the next cycle. cnt then increments.
//      - Gaps in ld_valid produce mem_web=1 cycles.
//      - After the N-th handshake: ld_ready=0 on the next cycle and the state goes to SWEEP.
//  - SWEEP:
//      - Drives addresses 0..N-1, one per cycle, with mem_web=1 throughout.
//      - A MEM_LAT-deep valid/last shift register tracks reads in flight.
//      - pt_data is registered from mem_rdata. For an address issued in cycle t, pt_valid=1 and pt_data=mem[addr] in cycle t+MEM_LAT+1.
//      - pt_last=1 together with the pt_valid of address N-1.
//      - After address N-1 is issued -> DRAIN.
//  - DRAIN: wait until the shift register is empty, i.e. the cycle after pt_last -> UPDATE.
//  - UPDATE:
//      - upd_req=1 until the cycle upd_ack=1; upd_req=0 on the following cycle.
//      - On ack, iter_count increments.
//      - upd_conv=1 -> DONE.
//      - Else, if the new iter_count == MAX_ITER -> DONE with timeout=1.
//      - Else -> SWEEP, restarting at address 0.
//  - DONE: done=1 for exactly one cycle -> IDLE.
//  - Ignored inputs:
//      - start while busy.
//      - ld_valid outside LOAD.
//      - upd_ack outside UPDATE.
//      - upd_ack arriving in the same cycle upd_req first rises is accepted.
//  - Counters:
//      - Address counter is ADDR_W+1 bits wide. N=4096 reaches address 4095 with no wrap.
//      - iter_count never exceeds MAX_ITER.
// CONFIGURATION
//  KMEANS_SKIP_LOAD_EN
//   - Defined:
//      - Adds input port reuse_data (1 bit), sampled with start.
//      - start with reuse_data=1 goes IDLE->SWEEP directly, using the SRAM contents and the N of the previous job.
//      - If no job has loaded since reset, the block behaves as if reuse_data=0.
//   - Undefined: port absent; every job runs LOAD.
// TESTING
//  - Reset mid-SWEEP with N=16: rst_n=0 -> same cycle busy=0, pt_valid=0, mem_web=1, state IDLE.
//  - MEM_LAT=2, N=4, load 0x0102,0x0304,0x0506,0x0708 back-to-back:
//      - mem_web=0 for 4 cycles at addr 0..3.
//      - Sweep: pt_valid rises 3 cycles after mem_addr=0 and pt_data follows that order.
//      - pt_last is set with 0x0708.
//  - Hold upd_conv=1 and ack 2 cycles after upd_req -> one sweep, done pulse, iter_count=1, timeout=0.
//  - MAX_ITER=3, upd_conv=0 always -> exactly 3 sweeps (12 pt_valid for N=4), done, iter_count=3, timeout=1.
//  - n_points=0 -> ld_ready never 1, done pulse within 2 cycles, iter_count=0. n_points=5000 -> 4096 loads.
//  - ld_valid toggling 1,0,1,0 with N=2: exactly 2 writes, to addr 0 and 1. start during SWEEP: no effect.

Source files
------------

// File: rtl/kmeans_iter_ctrl_if.sv
// Bus bundle for the k-means sequencer: host load stream, data SRAM port,
// point stream to the datapath and the centroid-update handshake.
interface kmeans_iter_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_web;
    logic [DATA_W-1:0] mem_rdata;

    logic              pt_valid;
    logic [DATA_W-1:0] pt_data;
    logic              pt_last;

    logic              upd_req;
    logic              upd_ack;
    logic              upd_conv;

    modport master (
        input  ld_valid, ld_data, mem_rdata, upd_ack, upd_conv,
        output ld_ready, mem_addr, mem_din, mem_web, pt_valid, pt_data, pt_last, upd_req
    );

    modport slave (
        output ld_valid, ld_data, mem_rdata, upd_ack, upd_conv,
        input  ld_ready, mem_addr, mem_din, mem_web, pt_valid, pt_data, pt_last, upd_req
    );
endinterface

// File: rtl/kmeans_iter_ctrl.sv
// k-means sequencer: loads points into the data SRAM, sweeps them to the datapath,
// handshakes centroid updates until convergence or MAX_ITER. Optional KMEANS_SKIP_LOAD_EN.
module kmeans_iter_ctrl #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 2,
    parameter int MAX_ITER = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [12:0]            n_points,
`ifdef KMEANS_SKIP_LOAD_EN
    input  logic                   reuse_data,
`endif
    kmeans_iter_ctrl_if.master     bus,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             iter_count,
    output logic                   timeout
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SWEEP, S_DRAIN, S_UPDATE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       n_q, n_d;
    logic                ld_ready_q, ld_ready_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic                mem_web_q, mem_web_d;
    logic [MEM_LAT:0]    vld_pipe_q, vld_pipe_d;
    logic [MEM_LAT:0]    last_pipe_q, last_pipe_d;
    logic                pt_valid_q, pt_valid_d;
    logic [DATA_W-1:0]   pt_data_q, pt_data_d;
    logic                pt_last_q, pt_last_d;
    logic                upd_req_q, upd_req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [7:0]          iter_q, iter_d;
    logic                timeout_q, timeout_d;

    logic [CW-1:0]       n_clamp;
    logic [CW-1:0]       cnt_inc;
    logic [7:0]          iter_nxt;
    logic                issue, issue_last;
    logic                reuse_ok;

`ifdef KMEANS_SKIP_LOAD_EN
    // Set once a full load has landed in the SRAM; a partial load invalidates it.
    logic have_q, have_d;
    assign reuse_ok = reuse_data & have_q;
`else
    assign reuse_ok = 1'b0;
`endif

    always_comb begin
        if ({19'd0, n_points} > 32'(DEPTH)) n_clamp = DEPTH;
        else                                n_clamp = CW'(n_points);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        ld_ready_d  = ld_ready_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_web_d   = 1'b1;
        upd_req_d   = upd_req_q;
        done_d      = 1'b0;
        iter_d      = iter_q;
        timeout_d   = timeout_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        cnt_inc     = cnt_q + CW'(1);
        iter_nxt    = iter_q + 8'd1;
`ifdef KMEANS_SKIP_LOAD_EN
        have_d      = have_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    iter_d    = 8'd0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    if (reuse_ok) begin
                        state_d = S_SWEEP;
                    end else if (n_clamp == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_LOAD;
                        n_d        = n_clamp;
                        ld_ready_d = 1'b1;
`ifdef KMEANS_SKIP_LOAD_EN
                        have_d     = 1'b0;
`endif
                    end
                end
            end
            S_LOAD: begin
                if (bus.ld_valid && ld_ready_q) begin
                    mem_addr_d = cnt_q[ADDR_W-1:0];
                    mem_din_d  = bus.ld_data;
                    mem_web_d  = 1'b0;
                    cnt_d      = cnt_inc;
                    if (cnt_inc == n_q) begin
                        cnt_d      = '0;
                        ld_ready_d = 1'b0;
                        state_d    = S_SWEEP;
`ifdef KMEANS_SKIP_LOAD_EN
                        have_d     = 1'b1;
`endif
                    end
                end
            end
            S_SWEEP: begin
                // The final write of LOAD may still be on the bus this cycle; reads follow it.
                mem_addr_d = cnt_q[ADDR_W-1:0];
                issue      = 1'b1;
                cnt_d      = cnt_inc;
                if (cnt_inc == n_q) begin
                    issue_last = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pt_last_q) begin
                    state_d   = S_UPDATE;
                    upd_req_d = 1'b1;
                end
            end
            S_UPDATE: begin
                if (bus.upd_ack) begin
                    upd_req_d = 1'b0;
                    iter_d    = iter_nxt;
                    if (bus.upd_conv) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (iter_nxt == 8'(MAX_ITER)) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = S_SWEEP;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Stage k of the pipe is the read issued k cycles ago; the top stage meets mem_rdata.
        vld_pipe_d  = {vld_pipe_q[MEM_LAT-1:0], issue};
        last_pipe_d = {last_pipe_q[MEM_LAT-1:0], issue_last};
        pt_valid_d  = vld_pipe_q[MEM_LAT];
        pt_last_d   = last_pipe_q[MEM_LAT];
        pt_data_d   = vld_pipe_q[MEM_LAT] ? bus.mem_rdata : pt_data_q;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            ld_ready_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_web_q   <= 1'b1;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            pt_valid_q  <= 1'b0;
            pt_data_q   <= '0;
            pt_last_q   <= 1'b0;
            upd_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            iter_q      <= 8'd0;
            timeout_q   <= 1'b0;
`ifdef KMEANS_SKIP_LOAD_EN
            have_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            ld_ready_q  <= ld_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_web_q   <= mem_web_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            pt_valid_q  <= pt_valid_d;
            pt_data_q   <= pt_data_d;
            pt_last_q   <= pt_last_d;
            upd_req_q   <= upd_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            iter_q      <= iter_d;
            timeout_q   <= timeout_d;
`ifdef KMEANS_SKIP_LOAD_EN
            have_q      <= have_d;
`endif
        end
    end

    assign bus.ld_ready = ld_ready_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_web  = mem_web_q;
    assign bus.pt_valid = pt_valid_q;
    assign bus.pt_data  = pt_data_q;
    assign bus.pt_last  = pt_last_q;
    assign bus.upd_req  = upd_req_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign iter_count   = iter_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Bench for kmeans_iter_ctrl: table of jobs plus random jobs against a job-level model,
// with an SRAM model and a monitor checking every write and every streamed point.
module tb_kmeans_iter_ctrl;
    localparam int MEM_LAT  = 2;
    localparam int MAX_ITER = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] n_points = '0;
    logic        busy, done, timeout;
    logic [7:0]  iter_count;
`ifdef KMEANS_SKIP_LOAD_EN
    logic        reuse_data = 1'b0;
`endif

    kmeans_iter_ctrl_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    kmeans_iter_ctrl #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(MEM_LAT), .MAX_ITER(MAX_ITER)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_points   (n_points),
`ifdef KMEANS_SKIP_LOAD_EN
        .reuse_data (reuse_data),
`endif
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .iter_count (iter_count),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // SRAM model with MEM_LAT cycles from address to read data
    logic [15:0] sram    [4096];
    logic [15:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        if (!bus.mem_web) sram[bus.mem_addr] <= bus.mem_din;
        rd_pipe[0] <= sram[bus.mem_addr];
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rdata = rd_pipe[MEM_LAT-1];

    // Monitor bookkeeping
    logic [15:0] exp_data [4096];
    int n_exp, wr_idx, pt_idx, pv_cnt, done_cnt, ldr_cnt, first_rd_cyc, first_pv_cyc, done_cyc;
    bit rd_seen, mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!bus.mem_web) begin
                chk("wr_addr", int'(bus.mem_addr), wr_idx);
                chk("wr_data", int'(bus.mem_din), (wr_idx < 4096) ? int'(exp_data[wr_idx]) : -1);
                wr_idx++;
            end else if (n_exp > 0 && wr_idx == n_exp && !rd_seen) begin
                rd_seen = 1'b1;
                first_rd_cyc = cyc;
                chk("first_rd_addr", int'(bus.mem_addr), 0);
            end
            if (bus.pt_valid) begin
                chk("pt_data", int'(bus.pt_data), int'(exp_data[pt_idx]));
                chk("pt_last", int'(bus.pt_last), int'(pt_idx == n_exp - 1));
                if (pv_cnt == 0) first_pv_cyc = cyc;
                pv_cnt++;
                pt_idx = (pt_idx + 1 >= n_exp) ? 0 : pt_idx + 1;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.ld_ready) ldr_cnt++;
        end
    end

    task automatic mon_reset(input int n);
        n_exp = n; wr_idx = 0; pt_idx = 0; pv_cnt = 0; done_cnt = 0; ldr_cnt = 0;
        first_rd_cyc = 0; first_pv_cyc = 0; done_cyc = 0; rd_seen = 1'b0;
        mon_en = 1'b1;
    endtask

    // mode 0: back-to-back, 1: toggling 1,0,1,0, 2: random gaps
    task automatic load_pts(input int n, input int mode);
        int i = 0, c = 0;
        bit hs;
        while (i < n && c < 4 * n + 40) begin
            bus.ld_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ~c[0] : 1'($urandom_range(0, 1));
            bus.ld_data  = exp_data[i];
            @(negedge clk);
            hs = bus.ld_valid && bus.ld_ready;
            @(posedge clk); #1;
            if (hs) i++;
            c++;
        end
        bus.ld_valid = 1'b0;
        if (i < n) chk("load_budget", i, n);
    endtask

    task automatic run_job(input int id, input int np, input int conv_at, input int dly, input int mode,
                           input bit fixed, input bit poke,
                           input int e_wr, input int e_pv, input int e_it, input int e_to);
        int n = (np > 4096) ? 4096 : np;
        int k = 0, w, st_cyc;
        for (int i = 0; i < n; i++)
            exp_data[i] = fixed ? 16'(((2 * i + 1) << 8) | (2 * i + 2)) : 16'($urandom);
        mon_reset(n);
        @(posedge clk); #1;
        start = 1'b1; n_points = 13'(np); st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (n > 0) begin
            load_pts(n, mode);
            if (poke) begin
                @(posedge clk); #1;
                start = 1'b1; n_points = 13'd7; bus.ld_valid = 1'b1; bus.ld_data = 16'hdead;
                @(posedge clk); #1;
                start = 1'b0; bus.ld_valid = 1'b0;
            end
            while (1) begin
                w = 0;
                do begin @(negedge clk); w++; end
                while (!bus.upd_req && done_cnt == 0 && w < n + 60);
                if (done_cnt != 0) break;
                if (!bus.upd_req) begin chk($sformatf("job%0d_upd_req_wait", id), 0, 1); break; end
                k++;
                repeat (dly) begin
                    @(negedge clk);
                    chk($sformatf("job%0d_upd_req_hold", id), int'(bus.upd_req), 1);
                end
                bus.upd_ack = 1'b1; bus.upd_conv = (k == conv_at);
                @(negedge clk);
                bus.upd_ack = 1'b0; bus.upd_conv = 1'b0;
                chk($sformatf("job%0d_upd_req_drop", id), int'(bus.upd_req), 0);
                if (k > MAX_ITER + 1) break;
            end
        end
        w = 0;
        while (done_cnt == 0 && w < 20) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
        chk($sformatf("job%0d_writes", id), wr_idx, e_wr);
        chk($sformatf("job%0d_pt_valids", id), pv_cnt, e_pv);
        chk($sformatf("job%0d_iter_count", id), int'(iter_count), e_it);
        chk($sformatf("job%0d_timeout", id), int'(timeout), e_to);
        chk($sformatf("job%0d_done_pulses", id), done_cnt, 1);
        chk($sformatf("job%0d_busy_after", id), int'(busy), 0);
        if (n == 0) begin
            chk($sformatf("job%0d_done_latency_le2", id), int'(done_cyc - st_cyc <= 2), 1);
            chk($sformatf("job%0d_ld_ready_cycles", id), ldr_cnt, 0);
        end else begin
            chk($sformatf("job%0d_acks", id), k, e_it);
            chk($sformatf("job%0d_read_latency", id), first_pv_cyc - first_rd_cyc, MEM_LAT + 1);
        end
        mon_en = 1'b0;
    endtask

    // Job-level reference: sweeps until the first converged ack or MAX_ITER acks.
    task automatic ref_model(input int np, input int conv_at,
                             output int e_wr, output int e_pv, output int e_it, output int e_to);
        int n = (np > 4096) ? 4096 : np;
        bit conv = (conv_at >= 1 && conv_at <= MAX_ITER);
        int sweeps = (n == 0) ? 0 : (conv ? conv_at : MAX_ITER);
        e_wr = n;
        e_pv = n * sweeps;
        e_it = sweeps;
        e_to = int'(n > 0 && !conv);
    endtask

    typedef struct {
        int np, conv_at, dly, mode;
        bit fixed, poke;
        int e_wr, e_pv, e_it, e_to;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int w, wb, e_wr, e_pv, e_it, e_to, np, ca;
        tbl[0] = '{4,    1, 2, 0, 1'b1, 1'b0, 4,    4,    1, 0};
        tbl[1] = '{4,    0, 0, 0, 1'b0, 1'b0, 4,    12,   3, 1};
        tbl[2] = '{2,    2, 1, 1, 1'b0, 1'b0, 2,    4,    2, 0};
        tbl[3] = '{0,    1, 0, 0, 1'b0, 1'b0, 0,    0,    0, 0};
        tbl[4] = '{1,    3, 3, 2, 1'b0, 1'b0, 1,    3,    3, 0};
        tbl[5] = '{37,   0, 1, 2, 1'b0, 1'b1, 37,   111,  3, 1};
        tbl[6] = '{5000, 1, 0, 0, 1'b0, 1'b0, 4096, 4096, 1, 0};

        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.upd_ack = 1'b0; bus.upd_conv = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mem_web", int'(bus.mem_web), 1);
        chk("rst_ld_ready", int'(bus.ld_ready), 0);
        chk("rst_pt_valid", int'(bus.pt_valid), 0);
        chk("rst_upd_req", int'(bus.upd_req), 0);
        chk("rst_iter_count", int'(iter_count), 0);
        chk("rst_timeout", int'(timeout), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int r = 0; r < 7; r++)
            run_job(r, tbl[r].np, tbl[r].conv_at, tbl[r].dly, tbl[r].mode, tbl[r].fixed, tbl[r].poke,
                    tbl[r].e_wr, tbl[r].e_pv, tbl[r].e_it, tbl[r].e_to);

        // Reset in the middle of a sweep with N=16
        for (int i = 0; i < 16; i++) exp_data[i] = 16'($urandom);
        mon_reset(16);
        @(posedge clk); #1;
        start = 1'b1; n_points = 13'd16;
        @(posedge clk); #1;
        start = 1'b0;
        load_pts(16, 0);
        w = 0;
        while (pv_cnt == 0 && w < 30) begin @(negedge clk); w++; end
        chk("midrst_sweep_reached", int'(pv_cnt > 0), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_pt_valid", int'(bus.pt_valid), 0);
        chk("midrst_mem_web", int'(bus.mem_web), 1);
        chk("midrst_upd_req", int'(bus.upd_req), 0);
        wb = wr_idx;
        repeat (3) @(negedge clk);
        chk("midrst_no_write", wr_idx, wb);
        chk("midrst_iter_count", int'(iter_count), 0);
        mon_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int r = 0; r < 8; r++) begin
            np = $urandom_range(0, 40);
            ca = $urandom_range(0, 4);
            ref_model(np, ca, e_wr, e_pv, e_it, e_to);
            run_job(100 + r, np, ca, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b0,
                    e_wr, e_pv, e_it, e_to);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
